// File: rtl/frame_pkg.sv
// Shared types and constants for the serial frame transmitter.
// A frame is start, channel, data, even parity and stop, sent LSB first.
package frame_pkg;

    localparam int DATA_W     = 16;
    localparam int CH_W       = 4;
    localparam int FRAME_BITS = 1 + CH_W + DATA_W + 1 + 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        CHAN,
        DATA,
        PARITY,
        STOP
    } state_t;

    // Returns the bit that makes the total count of ones over bits+result even.
    function automatic logic even_parity(input logic [31:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/bit_timer.sv
// Divides clk down to one bit_tick per serial bit period.
// The counter is held at zero while the line is idle or a frame is starting.
module bit_timer #(
    parameter int BIT_DIV = 4
) (
    input  logic clk,
    input  logic arst,
    input  logic clear,
    input  logic run,
    output logic bit_tick
);

    localparam int CW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(BIT_DIV - 1);

    logic [CW-1:0] div_cnt;

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            div_cnt <= '0;
        end else if (clear || !run || div_cnt == LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign bit_tick = run && (div_cnt == LAST);

endmodule

// File: rtl/frame_serializer.sv
// Line driver: takes one channel/word per handshake and shifts out a 23-bit
// frame (start, channel, data, even parity, stop) at BIT_DIV clocks per bit.
module frame_serializer #(
    parameter int DATA_W  = frame_pkg::DATA_W,
    parameter int CH_W    = frame_pkg::CH_W,
    parameter int BIT_DIV = 4
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CH_W-1:0]   in_channel,
    input  logic [DATA_W-1:0] in_data,
    output logic              tx_out,
    output logic              busy,
    output logic              frame_done
);

    import frame_pkg::*;

    localparam int SHIFT_W = CH_W + DATA_W + 1;
    localparam int CNT_W   = $clog2(DATA_W + 1);

    state_t             state;
    logic [CNT_W-1:0]   bit_cnt;
    logic [SHIFT_W-1:0] shift_q;
    logic               bit_tick;
    logic               running;
    logic               start_frame;

    // Channel 0 is the muxer's empty slot: it completes the handshake but sends nothing.
    assign start_frame = in_valid && in_ready && (in_channel != '0);
    assign running     = (state != IDLE);

    bit_timer #(
        .BIT_DIV(BIT_DIV)
    ) u_bit_timer (
        .clk     (clk),
        .arst    (arst),
        .clear   (start_frame),
        .run     (running),
        .bit_tick(bit_tick)
    );

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shift_q    <= '0;
            tx_out     <= 1'b1;
            in_ready   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (start_frame) begin
                        shift_q  <= {even_parity(32'({in_data, in_channel})), in_data, in_channel};
                        bit_cnt  <= '0;
                        tx_out   <= 1'b0;
                        busy     <= 1'b1;
                        in_ready <= 1'b0;
                        state    <= START;
                    end
                end
                START: begin
                    if (bit_tick) begin
                        tx_out  <= shift_q[0];
                        shift_q <= shift_q >> 1;
                        state   <= CHAN;
                    end
                end
                CHAN: begin
                    if (bit_tick) begin
                        tx_out  <= shift_q[0];
                        shift_q <= shift_q >> 1;
                        if (bit_cnt == CNT_W'(CH_W - 1)) begin
                            bit_cnt <= '0;
                            state   <= DATA;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                DATA: begin
                    // The bit shifted out after the last data bit is the parity bit.
                    if (bit_tick) begin
                        tx_out  <= shift_q[0];
                        shift_q <= shift_q >> 1;
                        if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                            bit_cnt <= '0;
                            state   <= PARITY;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (bit_tick) begin
                        tx_out <= 1'b1;
                        state  <= STOP;
                    end
                end
                STOP: begin
                    if (bit_tick) begin
                        busy       <= 1'b0;
                        in_ready   <= 1'b1;
                        frame_done <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/frame_serializer.md
Name: frame_serializer

Overview:
- Downstream of the channel input muxer.
- Accepts one 16-bit word plus its 4-bit channel ID per transfer through a valid/ready handshake.
- Builds a fixed serial frame from each transfer: start, channel, data, even parity, stop.
- Shifts the frame out on a single line at a programmable bit rate; this is the line driver stage of the transmitter.

Parameters:
- DATA_W, 16, payload width (matches the muxer output word).
- CH_W, 4, channel ID width.
- BIT_DIV, 4, clk cycles per serial bit (≥1).

Ports:
- clk  in  1  system clock, rising edge.
- arst  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_data/in_channel hold a word to send.
- in_ready  out  1  serializer can accept a word this cycle.
- in_channel  in  CH_W  channel ID of the word.
- in_data  in  DATA_W  payload word.
- tx_out  out  1  serial line; idles high.
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse at the end of the stop bit.

Behaviour:
- One clock domain; reset is asynchronous and active-low.
- Reset values:
  - tx_out=1, in_ready=0 while arst low.
  - in_ready=1 from the first clk after release.
  - busy=0, frame_done=0.
  - State IDLE; counters and shift register cleared.
- Frame, 23 bits, in transmit order:
  - start 0;
  - in_channel LSB first (4 bits);
  - in_data LSB first (16 bits);
  - parity = XOR of all channel and data bits, so the count of ones over channel+data+parity is even;
  - stop 1.
- Bit timing: every frame bit is driven for exactly BIT_DIV clk cycles. A div counter runs 0..BIT_DIV-1 and advances the bit on terminal count.
- Handshake:
  - Transfer occurs on a rising edge where in_valid && in_ready.
  - in_ready=1 only in IDLE.
  - in_data/in_channel are captured into registers at that edge; later input changes have no effect on the frame.
- Latency: the cycle after the transfer edge, tx_out=0 (start), busy=1, in_ready=0. All outputs are registered.
- States: IDLE → START → CHAN (4 bits) → DATA (16 bits) → PARITY → STOP → IDLE.
  - bit_cnt counts within CHAN and DATA.
- End of frame:
  - On the final edge of STOP: frame_done=1 for one cycle, busy=0, in_ready=1, tx_out stays 1.
  - Transfer edge to in_ready high is 23*BIT_DIV cycles.
- Back-to-back: if in_valid is held, the next word is accepted on the first edge with in_ready=1. The minimum idle-high gap between frames is 1 cycle.
- Channel 0 (the muxer's "no channel" output):
  - The transfer is accepted and the word dropped.
  - No frame is sent and tx_out stays 1.
  - in_ready stays 1; frame_done and busy stay 0.
- Channels 4..15 are transmitted unchanged; the serializer does not validate them.
- in_valid while busy is ignored (not captured). Upstream holds it until in_ready.
- Reset mid-frame: tx_out returns to 1 immediately and asynchronously. The frame is abandoned with no frame_done, and the captured word is discarded.

Decomposition:
- Package frame_pkg:
  - DATA_W, CH_W;
  - FRAME_BITS=23;
  - state enum {IDLE, START, CHAN, DATA, PARITY, STOP};
  - parity function.
- One sub-module, bit_timer: BIT_DIV counter producing bit_tick, with clear on frame start; clk/arst as above.

Test Plan:
- Reset: arst low with in_valid=1 → tx_out=1, in_ready=0, busy=0. After release, in_ready=1 and no transfer happens during reset.
- Single frame, channel 1, data 16'hA5C3, BIT_DIV=4:
  - Sampled bits are 0 | 1,0,0,0 | 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 | 1 | 1.
  - Each bit lasts 4 cycles.
  - frame_done pulses exactly 92 cycles after the transfer edge.
- Parity corners:
  - ch 3, data 16'h0000 → parity bit 0.
  - ch 2, data 16'hFFFF → parity bit 1.
- Channel 0 word: in_valid=1 one cycle → no frame, tx_out=1 throughout, in_ready remains 1, frame_done never asserted.
- Back-to-back: in_valid held with two words (ch1/16'h1234, ch2/16'h5678), BIT_DIV=1:
  - Exactly 1 idle-high cycle separates the frames.
  - Second frame carries 16'h5678.
  - Changing in_data during the first frame does not alter it.
- Reset mid-frame: assert arst during DATA bit 7 → tx_out=1 asynchronously, no frame_done. The next frame after release is complete and correct.
